// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADJ,
    SHIFT,
    DONE
  } state_e;

  localparam logic [3:0] ADD3       = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Smallest digit count D with 10^D > 2^bin_w.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned lim;
    longint unsigned p;
    int unsigned     d;
    lim = 64'd1 << bin_w;
    p   = 64'd10;
    d   = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin2bcd_seq_ctrl_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bin2bcd_seq_ctrl_cla4.sv
// 4-bit carry-lookahead adder (CLA4) built from propagate/generate full adders and a CLG.
module FA (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

module CLG (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c0,
  output logic [4:1] c
);
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);
endmodule

module CLA4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    FA u_fa (
      .a (a[i]),
      .b (b[i]),
      .c (carry[i]),
      .s (s[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  CLG u_clg (
    .p  (p),
    .g  (g),
    .c0 (carry[0]),
    .c  (carry[4:1])
  );

  assign cout = carry[4];
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential double-dabble converter: one shared CLA4 adjusts one BCD digit per cycle,
// then the working register shifts left; BIN_W*(DIGITS+1) cycles per conversion.
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  bin2bcd_seq_ctrl_if.slave  bus
);

  localparam int unsigned WORK_W = 4 * DIGITS + BIN_W;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $fatal(1, "bin2bcd_seq_ctrl: DIGITS too small for BIN_W");
  end

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [3:0] cur_digit;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       adj_hit;

  // Digit mux feeding the single shared adder.
  assign cur_digit = work_q[BIN_W + 4 * dig_q +: 4];
  assign adj_hit   = (cur_digit >= ADJ_THRESH);

  CLA4 u_add3 (
    .a    (cur_digit),
    .b    (ADD3),
    .cin  (1'b0),
    .s    (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    dig_d    = dig_q;
    bitcnt_d = bitcnt_q;
    bcd_d    = bcd_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          work_d   = WORK_W'(bus.bin_in);
          dig_d    = '0;
          bitcnt_d = '0;
          state_d  = ADJ;
        end else begin
          state_d  = IDLE;
        end
      end

      ADJ: begin
        if (adj_hit) begin
          work_d[BIN_W + 4 * dig_q +: 4] = add_sum;
        end
        if (dig_q == DIG_W'(DIGITS - 1)) begin
          dig_d   = '0;
          state_d = SHIFT;
        end else begin
          dig_d   = dig_q + 1'b1;
        end
      end

      SHIFT: begin
        work_d   = {work_q[WORK_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        dig_d    = '0;
        // Result is captured from the post-shift value so it is visible in DONE.
        if (bitcnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = work_d[WORK_W-1 -: 4*DIGITS];
          state_d = DONE;
        end else begin
          state_d = ADJ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      dig_q    <= '0;
      bitcnt_q <= '0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      dig_q    <= dig_d;
      bitcnt_q <= bitcnt_d;
      bcd_q    <= bcd_d;
    end
  end

  // A valid BCD digit (<= 9) plus 3 can never carry out of the nibble.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ADJ && adj_hit) begin
      assert (!add_cout);
    end
  end

  assign bus.busy    = (state_q == ADJ) || (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;

endmodule
